// File: rtl/halt_controller_if.sv
// Halt-controller bus: checker-stage halt inputs from the pipeline and halt status back to it.
interface halt_controller_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CYCLE_W = 32
) ();
  logic               ecall_valid;
  logic               ebreak_valid;
  logic               illegal_valid;
  logic [XLEN-1:0]    a7;
  logic               flush;
  logic               stall;
  logic               halt_req;
  logic               is_halted;
  logic [1:0]         halt_cause;
  logic [CYCLE_W-1:0] cycle_count;

  modport master (
    output ecall_valid, ebreak_valid, illegal_valid, a7, flush, stall,
    input  halt_req, is_halted, halt_cause, cycle_count
  );

  modport slave (
    input  ecall_valid, ebreak_valid, illegal_valid, a7, flush, stall,
    output halt_req, is_halted, halt_cause, cycle_count
  );
endinterface

// File: rtl/halt_controller.sv
// Halt unit: detects halt-causing instructions at the commit-safe stage, drains the pipe,
// then holds the core halted with a latched cause and a frozen cycle count.
module halt_controller #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned HALT_CODE    = 10,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter bit          EBREAK_HALT  = 1'b1,
  parameter bit          ILLEGAL_HALT = 1'b1,
  parameter int unsigned CYCLE_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  halt_controller_if.slave bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [1:0]         r_cause;
  logic [1:0]         w_next_cause;
  logic [CYCLE_W-1:0] r_cycle;
  logic [CYCLE_W-1:0] w_next_cycle;
  logic               r_halt_req;
  logic               r_is_halted;

  logic w_t_ecall;
  logic w_t_ebreak;
  logic w_t_ill;
  logic w_trigger;

  // Trigger qualification; only consulted while running.
  assign w_t_ecall  = bus.ecall_valid && (bus.a7 == XLEN'(HALT_CODE));
  assign w_t_ebreak = bus.ebreak_valid && EBREAK_HALT;
  assign w_t_ill    = bus.illegal_valid && ILLEGAL_HALT;
  assign w_trigger  = (w_t_ecall || w_t_ebreak || w_t_ill) && !bus.flush;

  // Next-state, drain counter, cause latch and saturating cycle counter.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_cause = r_cause;
    w_next_cycle = r_cycle;

    if ((r_state != S_HALTED) && !(&r_cycle)) begin
      w_next_cycle = r_cycle + CYCLE_W'(1);
    end

    case (r_state)
      S_RUN: begin
        if (w_trigger) begin
          if (w_t_ill) begin
            w_next_cause = CAUSE_ILLEGAL;
          end else if (w_t_ebreak) begin
            w_next_cause = CAUSE_EBREAK;
          end else begin
            w_next_cause = CAUSE_ECALL;
          end
          if (DRAIN_CYCLES == 0) begin
            w_next_state = S_HALTED;
          end else begin
            w_next_state = S_DRAIN;
            w_next_cnt   = CNT_W'(DRAIN_CYCLES);
          end
        end
      end
      S_DRAIN: begin
        if (!bus.stall) begin
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = S_HALTED;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      S_HALTED: begin
        w_next_state = S_HALTED;
      end
      default: begin
        w_next_state = S_RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they track the state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_cause     <= CAUSE_NONE;
      r_cycle     <= '0;
      r_halt_req  <= 1'b0;
      r_is_halted <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_cause     <= w_next_cause;
      r_cycle     <= w_next_cycle;
      r_halt_req  <= (w_next_state != S_RUN);
      r_is_halted <= (w_next_state == S_HALTED);
    end
  end

  assign bus.halt_req    = r_halt_req;
  assign bus.is_halted   = r_is_halted;
  assign bus.halt_cause  = r_cause;
  assign bus.cycle_count = r_cycle;

endmodule

// File: tb/tb_halt_controller.sv
// Self-checking bench: four parameter builds share one stimulus stream and are compared
// against a behavioural model, plus directed vector tables and corner-case sequences.
module tb_halt_controller;

  logic clk = 1'b0;
  logic reset;
  logic s_ecall, s_ebreak, s_illegal, s_flush, s_stall;
  logic [31:0] s_a7;

  always #5 clk = ~clk;

  halt_controller_if #(.XLEN(32), .CYCLE_W(32)) if0 ();
  halt_controller_if #(.XLEN(32), .CYCLE_W(32)) if1 ();
  halt_controller_if #(.XLEN(32), .CYCLE_W(32)) if2 ();
  halt_controller_if #(.XLEN(32), .CYCLE_W(4))  if3 ();

  assign if0.ecall_valid = s_ecall; assign if0.ebreak_valid = s_ebreak; assign if0.illegal_valid = s_illegal;
  assign if0.a7 = s_a7; assign if0.flush = s_flush; assign if0.stall = s_stall;
  assign if1.ecall_valid = s_ecall; assign if1.ebreak_valid = s_ebreak; assign if1.illegal_valid = s_illegal;
  assign if1.a7 = s_a7; assign if1.flush = s_flush; assign if1.stall = s_stall;
  assign if2.ecall_valid = s_ecall; assign if2.ebreak_valid = s_ebreak; assign if2.illegal_valid = s_illegal;
  assign if2.a7 = s_a7; assign if2.flush = s_flush; assign if2.stall = s_stall;
  assign if3.ecall_valid = s_ecall; assign if3.ebreak_valid = s_ebreak; assign if3.illegal_valid = s_illegal;
  assign if3.a7 = s_a7; assign if3.flush = s_flush; assign if3.stall = s_stall;

  halt_controller #(.XLEN(32), .HALT_CODE(10), .DRAIN_CYCLES(4), .EBREAK_HALT(1'b1),
                    .ILLEGAL_HALT(1'b1), .CYCLE_W(32))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  halt_controller #(.XLEN(32), .HALT_CODE(10), .DRAIN_CYCLES(4), .EBREAK_HALT(1'b1),
                    .ILLEGAL_HALT(1'b0), .CYCLE_W(32))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  halt_controller #(.XLEN(32), .HALT_CODE(10), .DRAIN_CYCLES(4), .EBREAK_HALT(1'b0),
                    .ILLEGAL_HALT(1'b0), .CYCLE_W(32))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  halt_controller #(.XLEN(32), .HALT_CODE(10), .DRAIN_CYCLES(0), .EBREAK_HALT(1'b1),
                    .ILLEGAL_HALT(1'b1), .CYCLE_W(4))
    u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  logic        o_req   [4];
  logic        o_halt  [4];
  logic [1:0]  o_cause [4];
  logic [31:0] o_cnt   [4];

  assign o_req[0] = if0.halt_req; assign o_halt[0] = if0.is_halted;
  assign o_cause[0] = if0.halt_cause; assign o_cnt[0] = if0.cycle_count;
  assign o_req[1] = if1.halt_req; assign o_halt[1] = if1.is_halted;
  assign o_cause[1] = if1.halt_cause; assign o_cnt[1] = if1.cycle_count;
  assign o_req[2] = if2.halt_req; assign o_halt[2] = if2.is_halted;
  assign o_cause[2] = if2.halt_cause; assign o_cnt[2] = if2.cycle_count;
  assign o_req[3] = if3.halt_req; assign o_halt[3] = if3.is_halted;
  assign o_cause[3] = if3.halt_cause; assign o_cnt[3] = 32'(if3.cycle_count);

  // Build parameters mirrored for the model.
  localparam int     P_DRAIN [4] = '{4, 4, 4, 0};
  localparam bit     P_EB    [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit     P_IL    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam longint P_CMAX  [4] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  // Model: has a halt been accepted, how many unstalled edges since, what cause, how many cycles.
  bit     m_trig  [4] = '{0, 0, 0, 0};
  int     m_ns    [4] = '{0, 0, 0, 0};
  int     m_cause [4] = '{0, 0, 0, 0};
  longint m_cnt   [4] = '{0, 0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rst, ec, eb, il;
    logic [31:0] a7;
    bit          fl, st;
    bit          req, halted;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_halted(input int i);
    return m_trig[i] && (m_ns[i] >= P_DRAIN[i]);
  endfunction

  task automatic model_edge();
    bit t_ec, t_eb, t_il;
    for (int i = 0; i < 4; i++) begin
      t_ec = s_ecall && (s_a7 == 32'd10);
      t_eb = s_ebreak && P_EB[i];
      t_il = s_illegal && P_IL[i];
      if (reset) begin
        m_trig[i] = 0; m_ns[i] = 0; m_cause[i] = 0; m_cnt[i] = 0;
      end else if (!m_halted(i)) begin
        if (m_cnt[i] < P_CMAX[i]) m_cnt[i]++;
        if (!m_trig[i]) begin
          if ((t_ec || t_eb || t_il) && !s_flush) begin
            m_trig[i]  = 1;
            m_ns[i]    = 0;
            m_cause[i] = t_il ? 3 : (t_eb ? 2 : 1);
          end
        end else if (!s_stall) begin
          m_ns[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("inst%0d halt_req", i),    32'(o_req[i]),   32'(m_trig[i]));
      check($sformatf("inst%0d is_halted", i),   32'(o_halt[i]),  32'(m_halted(i)));
      check($sformatf("inst%0d halt_cause", i),  32'(o_cause[i]), 32'(m_cause[i]));
      check($sformatf("inst%0d cycle_count", i), o_cnt[i],        32'(m_cnt[i]));
    end
  endtask

  task automatic set_in(input bit rst, input bit ec, input bit eb, input bit il,
                        input logic [31:0] a7, input bit fl, input bit st);
    reset = rst; s_ecall = ec; s_ebreak = eb; s_illegal = il; s_a7 = a7; s_flush = fl; s_stall = st;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 32'd0, 0, 0);
  endtask

  // One clock: inputs already applied, model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 32'd0, 0, 0);
    cycle();
    idle();
  endtask

  int rise_at;

  initial begin
    idle();
    reset = 1'b1;

    // Reset, 5 idle, halting ecall, drain of 4, then hold with late triggers ignored.
    tbl[0]  = '{1, 0, 0, 0, 32'd0,  0, 0, 0, 0, 2'd0, 32'd0};
    tbl[1]  = '{0, 0, 0, 0, 32'd0,  0, 0, 0, 0, 2'd0, 32'd1};
    tbl[2]  = '{0, 0, 0, 0, 32'd0,  0, 0, 0, 0, 2'd0, 32'd2};
    tbl[3]  = '{0, 0, 0, 0, 32'd0,  0, 0, 0, 0, 2'd0, 32'd3};
    tbl[4]  = '{0, 0, 0, 0, 32'd0,  0, 0, 0, 0, 2'd0, 32'd4};
    tbl[5]  = '{0, 0, 0, 0, 32'd0,  0, 0, 0, 0, 2'd0, 32'd5};
    tbl[6]  = '{0, 1, 0, 0, 32'd10, 0, 0, 1, 0, 2'd1, 32'd6};
    tbl[7]  = '{0, 0, 0, 0, 32'd0,  0, 0, 1, 0, 2'd1, 32'd7};
    tbl[8]  = '{0, 0, 1, 1, 32'd0,  0, 0, 1, 0, 2'd1, 32'd8};
    tbl[9]  = '{0, 0, 0, 0, 32'd0,  0, 0, 1, 0, 2'd1, 32'd9};
    tbl[10] = '{0, 0, 0, 0, 32'd0,  0, 0, 1, 1, 2'd1, 32'd10};
    tbl[11] = '{0, 1, 1, 1, 32'd10, 0, 0, 1, 1, 2'd1, 32'd10};
    tbl[12] = '{0, 0, 0, 0, 32'd0,  0, 1, 1, 1, 2'd1, 32'd10};

    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      set_in(tbl[k].rst, tbl[k].ec, tbl[k].eb, tbl[k].il, tbl[k].a7, tbl[k].fl, tbl[k].st);
      cycle();
      check($sformatf("vec%0d halt_req", k),    32'(o_req[0]),   32'(tbl[k].req));
      check($sformatf("vec%0d is_halted", k),   32'(o_halt[0]),  32'(tbl[k].halted));
      check($sformatf("vec%0d halt_cause", k),  32'(o_cause[0]), 32'(tbl[k].cause));
      check($sformatf("vec%0d cycle_count", k), o_cnt[0],        tbl[k].cnt);
    end
    idle();
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("frozen cycle_count", o_cnt[0], 32'd10);
    end

    // Non-matching a7 values, including an upper-bit alias of the halt code.
    do_reset();
    set_in(0, 1, 0, 0, 32'd9, 0, 0);           cycle(); check("a7=9 halt_req", 32'(o_req[0]), 32'd0);
    set_in(0, 1, 0, 0, 32'h0000_010A, 0, 0);   cycle(); check("a7=10A halt_req", 32'(o_req[0]), 32'd0);
    set_in(0, 1, 0, 0, 32'h8000_000A, 0, 0);   cycle(); check("a7=8000000A halt_req", 32'(o_req[0]), 32'd0);
    check("no-op ecall cause", 32'(o_cause[0]), 32'd0);

    // Flushed ecall ignored, same ecall next cycle accepted.
    do_reset();
    set_in(0, 1, 0, 0, 32'd10, 1, 0);  cycle(); check("flushed ecall halt_req", 32'(o_req[0]), 32'd0);
    set_in(0, 1, 0, 0, 32'd10, 0, 0);  cycle(); check("ecall after flush halt_req", 32'(o_req[0]), 32'd1);
    check("ecall after flush cause", 32'(o_cause[0]), 32'd1);

    // Three stalled drain cycles stretch the drain to 7 edges; mid-drain ebreak ignored.
    do_reset();
    set_in(0, 1, 0, 0, 32'd10, 0, 0);
    cycle();
    rise_at = 0;
    for (int k = 1; k <= 10; k++) begin
      set_in(0, 0, (k == 2), 0, 32'd0, 0, (k <= 3));
      cycle();
      if (o_halt[0] && rise_at == 0) rise_at = k;
    end
    check("stalled drain length", 32'(rise_at), 32'd7);
    check("stalled drain cause", 32'(o_cause[0]), 32'd1);

    // Coincident triggers across the enable builds; DRAIN_CYCLES=0 halts on the trigger edge.
    do_reset();
    set_in(0, 1, 1, 1, 32'd10, 0, 0);
    cycle();
    idle();
    check("all-three cause inst0", 32'(o_cause[0]), 32'd3);
    check("all-three cause inst1", 32'(o_cause[1]), 32'd2);
    check("all-three cause inst2", 32'(o_cause[2]), 32'd1);
    check("drain0 is_halted", 32'(o_halt[3]), 32'd1);
    check("drain4 not yet halted", 32'(o_halt[0]), 32'd0);

    // Reset two cycles into the drain.
    do_reset();
    set_in(0, 1, 0, 0, 32'd10, 0, 0); cycle();
    idle(); cycle(); cycle();
    set_in(1, 0, 0, 0, 32'd0, 0, 0); cycle();
    check("mid-drain reset halt_req", 32'(o_req[0]), 32'd0);
    check("mid-drain reset is_halted", 32'(o_halt[0]), 32'd0);
    check("mid-drain reset cause", 32'(o_cause[0]), 32'd0);
    check("mid-drain reset cycle_count", o_cnt[0], 32'd0);

    // Saturation of the 4-bit counter build.
    idle();
    for (int k = 0; k < 20; k++) cycle();
    check("4-bit cycle_count saturates", o_cnt[3], 32'd15);
    check("32-bit cycle_count", o_cnt[0], 32'd20);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 199) == 0);
      s_ecall   = ($urandom_range(0, 7) == 0);
      s_ebreak  = ($urandom_range(0, 15) == 0);
      s_illegal = ($urandom_range(0, 23) == 0);
      s_flush   = ($urandom_range(0, 3) == 0);
      s_stall   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1:    s_a7 = 32'd10;
        2:       s_a7 = 32'd9;
        default: s_a7 = $urandom;
      endcase
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
